// File: rtl/ysyx_22040759_imem_pkg.sv
// Shared constants and helpers for the IF-stage instruction memory responder.
package ysyx_22040759_imem_pkg;

  localparam logic [63:0] IMEM_BASE  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam int unsigned IMEM_DEPTH = 4096;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ysyx_22040759_imem_chk.sv
// Address decoder shared by the fetch and loader ports: byte address -> (in-map, word index).
module ysyx_22040759_imem_chk
  import ysyx_22040759_imem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = IMEM_BASE,
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic [63:0]   addr_i,
  output logic          ok_o,
  output logic [AW-1:0] idx_o
);

  // BASE_ADDR is word aligned, so the word offset is exactly the difference of the word fields.
  logic [61:0] woff;

  assign woff  = addr_i[63:2] - BASE_ADDR[63:2];
  assign ok_o  = (addr_i >= BASE_ADDR) && (addr_i[1:0] == 2'b00) &&
                 (woff < 62'(DEPTH_WORDS));
  assign idx_o = woff[AW-1:0];

endmodule

// File: rtl/ysyx_22040759_imem.sv
// Instruction memory responder: 1-cycle registered fetch port, loader write port, fetch counter.
module ysyx_22040759_imem
  import ysyx_22040759_imem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = IMEM_BASE,
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH,
  parameter logic [31:0] NOP_INST    = INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ram_en,
  input  logic [63:0] inst_raddr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        inst_fault,
  input  logic        ld_en,
  input  logic [63:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_err,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic          rd_ok, ld_ok;
  logic [AW-1:0] rd_idx, ld_idx;

  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        ld_err_q, ld_err_d;
  logic [31:0] cnt_q, cnt_d;

  ysyx_22040759_imem_chk #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS)) u_rd_chk (
    .addr_i (inst_raddr),
    .ok_o   (rd_ok),
    .idx_o  (rd_idx)
  );

  ysyx_22040759_imem_chk #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS)) u_ld_chk (
    .addr_i (ld_addr),
    .ok_o   (ld_ok),
    .idx_o  (ld_idx)
  );

  // NOTE: the array has no reset branch; reset only gates writes so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && ld_en && ld_ok) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    inst_d   = inst_q;
    fault_d  = fault_q;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    ld_err_d = ld_en && !ld_ok;
    if (i_ram_en) begin
      valid_d = 1'b1;
      cnt_d   = sat_inc32(cnt_q);
      if (rd_ok) begin
        // Write-first: a same-cycle loader write to the fetched word is forwarded.
        inst_d  = (ld_en && ld_ok && (ld_idx == rd_idx)) ? ld_data : mem[rd_idx];
        fault_d = 1'b0;
      end else begin
        inst_d  = NOP_INST;
        fault_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      ld_err_q <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      ld_err_q <= ld_err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign inst_fault = fault_q;
  assign ld_err     = ld_err_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: doc/ysyx_22040759_imem.md
Name: ysyx_22040759_imem

Overview:
Instruction-memory responder on the far side of the IF-stage instruction SRAM interface. It accepts fetch requests (i_ram_en, inst_raddr) and returns the 32-bit instruction one clock later on inst. The fetch stage latches that value as fs_inst.
It also provides a loader write port for bench/boot preload, address-fault reporting and a fetch counter. Memory is word-organised and mapped at BASE_ADDR.

Parameters:
BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
DEPTH_WORDS, 4096, number of 32-bit words (power of two); index width AW = clog2(DEPTH_WORDS), a localparam.
NOP_INST, 32'h0000_0013, value driven on inst after reset and on faulting reads.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
i_ram_en  in  1  fetch request strobe, sampled at posedge.
inst_raddr  in  64  fetch byte address (IF nextpc).
inst  out  32  registered read data.
inst_valid  out  1  high the cycle after an accepted request.
inst_fault  out  1  registered with inst; last request was misaligned or out of range.
ld_en  in  1  loader write strobe.
ld_addr  in  64  loader byte address.
ld_data  in  32  loader write word.
ld_err  out  1  one-cycle pulse: last loader write was dropped (bad address).
fetch_cnt  out  32  number of accepted requests, saturating.

Behaviour:
- Clock and reset: clk, with reset rst, synchronous, active-high. All state updates occur on posedge clk.
- Reset values: inst=NOP_INST, inst_valid=0, inst_fault=0, ld_err=0, fetch_cnt=0. Memory array contents are not reset.
- While rst=1, both read and write strobes are ignored, including a write on the cycle rst deasserts' preceding edge.
- Address check, shared by read and write:
  - off = addr - BASE_ADDR, 64-bit.
  - ok = (addr >= BASE_ADDR) & (addr[1:0]==2'b00) & (off[63:2] < DEPTH_WORDS).
  - idx = off[AW+1:2].
- Read, latency 1: at posedge with i_ram_en=1:
  - ok: inst <= mem[idx], inst_fault <= 0.
  - !ok: inst <= NOP_INST, inst_fault <= 1.
  - In both cases inst_valid <= 1.
- No request: at posedge with i_ram_en=0, inst and inst_fault hold their previous values and inst_valid <= 0. This keeps fs_inst stable while IF stalls (ds_allowin=0).
- Write: at posedge with ld_en=1:
  - ok: mem[idx] <= ld_data, ld_err <= 0.
  - !ok: no write, ld_err <= 1.
  - When ld_en=0: ld_err <= 0.
- Simultaneous read and write to the same idx (both ok): write-first. inst <= ld_data, and mem is updated.
- Simultaneous read and write to different idx: independent; inst gets the old mem[read idx].
- fetch_cnt: +1 on every accepted request, faulting or not. Holds at 32'hFFFF_FFFF.
- Back-to-back requests: one per cycle, no bubbles; inst updates every cycle.
- Reset mid-stream: an outstanding response is discarded; outputs return to reset values on the next edge.

Decomposition:
- ysyx_22040759_define.v gains:
  - `IMEM_BASE 64'h8000_0000
  - `INST_NOP 32'h0000_0013
  - These are the parameter defaults.
- One combinational sub-module, ysyx_22040759_imem_chk (addr -> ok, idx), instantiated twice: read port and loader port.
- The array is a reg [31:0] mem[0:DEPTH_WORDS-1] in the top module.

Test Plan:
1. Reset then idle -> inst=32'h00000013, inst_valid=0, inst_fault=0, fetch_cnt=0.
2. Load mem[0]=32'h00100093 at ld_addr 0x80000000 and mem[1]=32'h00208113 at 0x80000004. Then fetch 0x80000000 and 0x80000004 on consecutive cycles -> inst=00100093, then 00208113 (1-cycle latency), inst_valid=1,1, fetch_cnt=2.
3. Fetch 0x80000000, then hold i_ram_en=0 for 3 cycles -> inst stays 00100093, inst_valid=0 for those 3 cycles.
4. Fetch 0x80000002 -> inst_fault=1, inst=00000013. Fetch 0x7FFFFFFC -> fault. Fetch 0x80000000+4*4096 -> fault. Fetch 0x80003FFC -> no fault.
5. Same cycle: ld_en to 0x80000008 with data DEADBEEF and fetch 0x80000008 -> inst=DEADBEEF next cycle. ld_en to 0x90000000 -> ld_err pulses 1 cycle and no memory change.
6. Assert rst while i_ram_en=1 streaming -> next edge inst=00000013, inst_valid=0, fetch_cnt=0. A ld_en during rst leaves the target word unchanged.
